// File: rtl/register_bank.sv
// Parametrised integer register bank: NUM_READ combinational read ports, one write port,
// x0 hardwired to zero, hardware clear sweep. Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
module register_bank #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int NUM_READ = 2,
  parameter int ADDR_W   = $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  output logic                         ready,
  input  logic                         write_en,
  input  logic [ADDR_W-1:0]            write_addr,
  input  logic [WORDSIZE-1:0]          write_data,
  output logic                         wr_drop,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*WORDSIZE-1:0] rd_data
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]          state;
  logic [ADDR_W-1:0]   idx;
  logic [WORDSIZE-1:0] regs [SIZE];
  logic                write_ok;
  logic                sweep_last;

  assign ready      = (state == ST_IDLE);
  assign write_ok   = ready && write_en && !clear_req && !reset && (write_addr != '0);
  assign wr_drop    = write_en && (!ready || clear_req || reset);
  assign sweep_last = (idx == ADDR_W'(SIZE - 1));

  // The sweep starts at 1 because x0 is never stored; idx parks at SIZE-1 instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      idx   <= ADDR_W'(1);
    end else if (state == ST_CLEAR) begin
      if (sweep_last) begin
        state <= ST_IDLE;
      end else begin
        idx <= idx + ADDR_W'(1);
      end
    end else if (clear_req) begin
      state <= ST_CLEAR;
      idx   <= ADDR_W'(1);
    end
  end

  // Storage has no reset of its own so it can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_CLEAR) begin
      regs[idx] <= '0;
    end else if (write_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0]   ra;
    logic [WORDSIZE-1:0] val;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = '0;
      if (ready && ra != '0) begin
        val = regs[ra];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && write_addr == ra) begin
          val = write_data;
        end
`endif
      end
    end

    assign rd_data[k*WORDSIZE +: WORDSIZE] = val;
  end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: a 32x64 two-port bank (dut_a) and a 16x32 three-port bank (dut_b).
module tb_register_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear_req, write_en, ready, wr_drop;
  logic [4:0]   write_addr;
  logic [63:0]  write_data;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;

  logic         clear_req_b, write_en_b, ready_b, wr_drop_b;
  logic [3:0]   write_addr_b;
  logic [31:0]  write_data_b;
  logic [11:0]  rd_addr_b;
  logic [95:0]  rd_data_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } item_t;

  item_t sb_q[$];

  always #5 clk = ~clk;

  register_bank #(.WORDSIZE(64), .SIZE(32), .NUM_READ(2)) dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .wr_drop(wr_drop), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  register_bank #(.WORDSIZE(32), .SIZE(16), .NUM_READ(3)) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req_b), .ready(ready_b),
    .write_en(write_en_b), .write_addr(write_addr_b), .write_data(write_data_b),
    .wr_drop(wr_drop_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
  );

  function automatic logic [63:0] actual_of(int sel);
    case (sel)
      0:       return {63'd0, ready};
      1:       return {63'd0, wr_drop};
      2:       return rd_data[63:0];
      3:       return rd_data[127:64];
      4:       return {63'd0, ready_b};
      5:       return {32'd0, rd_data_b[31:0]};
      6:       return {32'd0, rd_data_b[63:32]};
      7:       return {32'd0, rd_data_b[95:64]};
      default: return {63'd0, wr_drop_b};
    endcase
  endfunction

  task automatic checkOutput(input item_t it);
    logic [63:0] act;
    act = actual_of(it.sel);
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", it.name, act, it.exp, $time);
    end
  endtask

  // Monitor: every expectation queued during a cycle is checked mid-cycle, away from the edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                               input logic cr, input logic [4:0] r0, input logic [4:0] r1);
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    clear_req  = cr;
    rd_addr    = {r1, r0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    clear_req_b = 1'b0; write_en_b = 1'b0; write_addr_b = '0; write_data_b = '0; rd_addr_b = '0;
    step();
    step();
    applyStimulus(1'b1, 5'd3, 64'h11, 1'b0, 5'd3, 5'd0);
    expect_val("reset_ready", 0, 64'd0);
    expect_val("reset_write_drop", 1, 64'd1);
    expect_val("reset_ready_b", 4, 64'd0);
    step();

    // Initial sweep: both banks share the reset release.
    reset = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'(c), 5'd0);
      expect_val("init_ready", 0, 64'd0);
      expect_val("init_drop", 1, 64'd0);
      expect_val("init_read_zero", 2, 64'd0);
      expect_val("init_ready_b", 4, (c <= 15) ? 64'd0 : 64'd1);
      step();
    end
    expect_val("init_ready_up", 0, 64'd1);

    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'(a), 5'(31 - a));
      rd_addr_b = {4'(15 - (a % 16)), 4'((a + 5) % 16), 4'(a % 16)};
      expect_val("zero_p0", 2, 64'd0);
      expect_val("zero_p1", 3, 64'd0);
      expect_val("zero_b_p0", 5, 64'd0);
      expect_val("zero_b_p1", 6, 64'd0);
      expect_val("zero_b_p2", 7, 64'd0);
      step();
    end

    // Small bank: three writes then a simultaneous three-port read.
    write_en_b = 1'b1;
    write_addr_b = 4'd3;  write_data_b = 32'd7;         step();
    write_addr_b = 4'd9;  write_data_b = 32'd11;        step();
    write_addr_b = 4'd15; write_data_b = 32'hFFFF_FFFF; step();
    write_en_b = 1'b0;
    rd_addr_b = {4'd15, 4'd9, 4'd3};
    expect_val("b_port0_x3", 5, 64'd7);
    expect_val("b_port1_x9", 6, 64'd11);
    expect_val("b_port2_x15", 7, 64'h0000_0000_FFFF_FFFF);
    expect_val("b_drop", 8, 64'd0);
    step();

    applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    expect_val("wr_x5_drop", 1, 64'd0);
    step();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd5);
    expect_val("rd_x5_p0", 2, 64'hDEAD_BEEF);
    expect_val("rd_x5_p1", 3, 64'hDEAD_BEEF);
    step();
    applyStimulus(1'b1, 5'd0, 64'h1234, 1'b0, 5'd0, 5'd5);
    expect_val("wr_x0_drop", 1, 64'd0);
    step();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5);
    expect_val("rd_x0", 2, 64'd0);
    step();

    applyStimulus(1'b1, 5'd7, 64'hA5, 1'b0, 5'd7, 5'd5);
`ifdef REGFILE_BYPASS_EN
    expect_val("same_cycle_x7", 2, 64'hA5);
`else
    expect_val("same_cycle_x7", 2, 64'd0);
`endif
    expect_val("same_cycle_x5", 3, 64'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 5'd0);
    expect_val("next_cycle_x7", 2, 64'hA5);
    step();

    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 64'(i * 3), 1'b0, 5'd0, 5'd0);
      step();
    end
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'(i), 5'(32 - i));
      expect_val("fill_p0", 2, 64'(i * 3));
      expect_val("fill_p1", 3, 64'((32 - i) * 3));
      step();
    end

    // Clear request with a colliding write; a second request mid-sweep must not restart it.
    applyStimulus(1'b1, 5'd4, 64'h99, 1'b1, 5'd4, 5'd0);
    expect_val("clear_write_drop", 1, 64'd1);
    expect_val("clear_ready_still", 0, 64'd1);
    expect_val("clear_rd_x4_old", 2, 64'd12);
    step();
    for (int c = 1; c <= 31; c++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, (c == 3), 5'd4, 5'd31);
      expect_val("clear_ready", 0, 64'd0);
      expect_val("clear_rd_p0", 2, 64'd0);
      expect_val("clear_rd_p1", 3, 64'd0);
      step();
    end
    expect_val("clear_ready_up", 0, 64'd1);
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'(a), 5'(32 - a));
      expect_val("cleared_p0", 2, 64'd0);
      expect_val("cleared_p1", 3, 64'd0);
      step();
    end

    applyStimulus(1'b1, 5'd20, 64'h55, 1'b0, 5'd0, 5'd0); step();
    applyStimulus(1'b1, 5'd2, 64'h66, 1'b0, 5'd0, 5'd0);  step();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd20, 5'd2);
    expect_val("pre_rst_x20", 2, 64'h55);
    expect_val("pre_rst_x2", 3, 64'h66);
    step();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0);
    step();
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
      expect_val("sweep_ready", 0, 64'd0);
      step();
    end

    // Reset lands on sweep cycle 10 and must restart the full sweep.
    reset = 1'b1;
    applyStimulus(1'b1, 5'd20, 64'h1, 1'b0, 5'd0, 5'd0);
    expect_val("midsweep_rst_drop", 1, 64'd1);
    step();
    reset = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      applyStimulus((c == 5), 5'd2, 64'h77, 1'b0, 5'd2, 5'd20);
      expect_val("restart_ready", 0, 64'd0);
      expect_val("restart_drop", 1, (c == 5) ? 64'd1 : 64'd0);
      step();
    end
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd2, 5'd20);
    expect_val("restart_ready_up", 0, 64'd1);
    expect_val("restart_x2", 2, 64'd0);
    expect_val("restart_x20", 3, 64'd0);
    step();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
